// File: rtl/muldiv_ctrl.sv
// HI/LO owner for the EX stage: sequential shift-add multiply and restoring divide.
// Optional build macro MULDIV_DIV0_TRAP_EN turns divide-by-zero into a one-cycle div0_err pulse.
module muldiv_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              op_valid,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] Rdata1,
  input  logic [DATA_W-1:0] Rdata2,
  input  logic              kill,
  output logic              stall,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] mf_data,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              div0_err
);

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

  state_e                state_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  is_div_q;
  logic                  neg_lo_q;
  logic                  neg_hi_q;
  logic [CNT_W-1:0]      count_q;
  logic [2*DATA_W-1:0]   acc_q;
  logic [DATA_W-1:0]     b_q;
  logic [DATA_W-1:0]     hi_q;
  logic [DATA_W-1:0]     lo_q;

  logic                  dec_mfhi, dec_mflo, dec_mt, dec_mul, dec_div;
  logic                  recognised, accept, start_op, trap_div0;
  logic                  op_signed, sa, sb, rt_zero;
  logic [DATA_W-1:0]     abs_a, abs_b;

  logic [DATA_W:0]       mul_sum;
  logic [DATA_W:0]       div_shift;
  logic                  div_ge;
  logic [DATA_W-1:0]     div_rem;
  logic [2*DATA_W-1:0]   step_d;
  logic [DATA_W-1:0]     fix_hi_d, fix_lo_d;

  assign dec_mfhi   = (funct == F_MFHI);
  assign dec_mflo   = (funct == F_MFLO);
  assign dec_mt     = (funct == F_MTHI) | (funct == F_MTLO);
  assign dec_mul    = (funct == F_MULT) | (funct == F_MULTU);
  assign dec_div    = (funct == F_DIV)  | (funct == F_DIVU);
  assign recognised = op_valid & (dec_mfhi | dec_mflo | dec_mt | dec_mul | dec_div);

  assign stall  = recognised & busy_q & ~kill;
  assign accept = recognised & ~busy_q & ~kill;

  assign op_signed = ~funct[0];
  assign sa        = op_signed & Rdata1[DATA_W-1];
  assign sb        = op_signed & Rdata2[DATA_W-1];
  assign abs_a     = sa ? -Rdata1 : Rdata1;
  assign abs_b     = sb ? -Rdata2 : Rdata2;
  assign rt_zero   = (Rdata2 == '0);

`ifdef MULDIV_DIV0_TRAP_EN
  assign trap_div0 = dec_div & rt_zero;
`else
  assign trap_div0 = 1'b0;
`endif

  assign start_op = accept & (dec_mul | dec_div) & ~trap_div0;

  // Multiply keeps {partial, multiplier} in acc; divide keeps {remainder, dividend}.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, b_q} : '0);
    div_shift = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
    div_ge    = (div_shift >= {1'b0, b_q});
    div_rem   = div_ge ? (div_shift[DATA_W-1:0] - b_q) : div_shift[DATA_W-1:0];
    step_d    = is_div_q ? {div_rem, acc_q[DATA_W-2:0], div_ge}
                         : {mul_sum, acc_q[DATA_W-1:1]};
    if (!is_div_q) begin
      {fix_hi_d, fix_lo_d} = neg_lo_q ? -acc_q : acc_q;
    end else begin
      fix_lo_d = neg_lo_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
      fix_hi_d = neg_hi_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      count_q  <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (accept && dec_mt) begin
            if (funct[1]) lo_q <= Rdata1;
            else          hi_q <= Rdata1;
          end
          if (start_op) begin
            state_q  <= S_CALC;
            busy_q   <= 1'b1;
            count_q  <= '0;
            is_div_q <= dec_div;
            if (dec_div && rt_zero) begin
              // Raw dividend and no sign fix: leaves lo=all-ones, hi=rs.
              acc_q    <= {{DATA_W{1'b0}}, Rdata1};
              b_q      <= '0;
              neg_lo_q <= 1'b0;
              neg_hi_q <= 1'b0;
            end else if (dec_div) begin
              acc_q    <= {{DATA_W{1'b0}}, abs_a};
              b_q      <= abs_b;
              neg_lo_q <= sa ^ sb;
              neg_hi_q <= sa;
            end else begin
              acc_q    <= {{DATA_W{1'b0}}, abs_b};
              b_q      <= abs_a;
              neg_lo_q <= sa ^ sb;
              neg_hi_q <= sa ^ sb;
            end
          end
        end
        S_CALC: begin
          if (kill) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q   <= step_d;
            count_q <= count_q + CNT_W'(1);
            if (count_q == CNT_W'(DATA_W - 1)) begin
              state_q <= S_FIX;
              done_q  <= 1'b1;
            end
          end
        end
        S_FIX: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          if (!kill) begin
            hi_q <= fix_hi_d;
            lo_q <= fix_lo_d;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef MULDIV_DIV0_TRAP_EN
  logic div0_err_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) div0_err_q <= 1'b0;
    else      div0_err_q <= accept & trap_div0;
  end

  assign div0_err = div0_err_q;
`else
  assign div0_err = 1'b0;
`endif

  always_comb begin
    mf_data = '0;
    if (op_valid && dec_mfhi)      mf_data = hi_q;
    else if (op_valid && dec_mflo) mf_data = lo_q;
  end

  // A kill landing in FIX suppresses the commit, so the pulse is masked too.
  assign done = done_q & ~kill;
  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed scenarios plus randomized MUL/DIV
// against a 64-bit arithmetic reference.
module tb_muldiv_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        op_valid;
  logic [5:0]  funct;
  logic [31:0] Rdata1;
  logic [31:0] Rdata2;
  logic        kill;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] mf_data;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div0_err;

  int passed = 0;
  int total  = 0;
  logic [31:0] m_hi, m_lo;

  muldiv_ctrl #(.DATA_W(32), .CNT_W(6)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .op_valid (op_valid),
    .funct    (funct),
    .Rdata1   (Rdata1),
    .Rdata2   (Rdata2),
    .kill     (kill),
    .stall    (stall),
    .busy     (busy),
    .done     (done),
    .mf_data  (mf_data),
    .hi       (hi),
    .lo       (lo),
    .div0_err (div0_err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l);
    longint      sa, sb, q, r;
    logic [63:0] p;
    p = '0; sa = 0; sb = 0; q = 0; r = 0;
    h = '0; l = '0;
    case (f)
      6'h18: begin
        p = longint'($signed(a)) * longint'($signed(b));
        h = p[63:32]; l = p[31:0];
      end
      6'h19: begin
        p = {32'b0, a} * {32'b0, b};
        h = p[63:32]; l = p[31:0];
      end
      6'h1A, 6'h1B: begin
        if (b == 0) begin
          l = 32'hFFFF_FFFF; h = a;
        end else if (f == 6'h1A) begin
          sa = longint'($signed(a));
          sb = longint'($signed(b));
          q = sa / sb;
          r = sa % sb;
          l = q[31:0]; h = r[31:0];
        end else begin
          l = a / b; h = a % b;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic start(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1; funct = f; Rdata1 = a; Rdata2 = b;
    #1;
    chk("accept_no_stall", stall, 0);
    @(posedge CLK); #1;
    op_valid = 1'b0; funct = 6'h00;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin
      @(posedge CLK); #1;
      cyc++;
    end
  endtask

  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eh, el;
    int cyc;
    model(f, a, b, eh, el);
    start(f, a, b);
    chk("busy_after_accept", busy, 1);
    wait_done(cyc);
    chk("done_cycle", cyc, 33);
    chk("busy_in_fix", busy, 1);
    @(posedge CLK); #1;
    chk("busy_cleared", busy, 0);
    chk("done_one_cycle", done, 0);
    chk("hi_result", hi, eh);
    chk("lo_result", lo, el);
    m_hi = eh; m_lo = el;
  endtask

  initial begin
    logic [31:0] eh, el, a, b;
    logic [5:0]  f;
    int cyc, n;

    RST = 1'b0; op_valid = 1'b0; funct = '0; Rdata1 = '0; Rdata2 = '0; kill = 1'b0;
    m_hi = '0; m_lo = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_div0", div0_err, 0);
    chk("rst_stall", stall, 0);
    RST = 1'b1;
    @(posedge CLK); #1;

    run_op(6'h19, 32'd6, 32'd7);
    chk("multu_lo_42", lo, 32'd42);
    run_op(6'h18, 32'hFFFF_FFFE, 32'd3);
    chk("mult_hi_neg", hi, 32'hFFFF_FFFF);
    run_op(6'h1A, 32'hFFFF_FFF9, 32'd2);
    chk("div_lo_neg", lo, 32'hFFFF_FFFD);
    run_op(6'h1B, 32'd100, 32'd7);
    run_op(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_wrap_lo", lo, 32'h8000_0000);
    run_op(6'h1A, 32'd7, 32'hFFFF_FFFE);

    // MFLO presented during a multiply stalls until the commit
    model(6'h18, 32'hFFFF_0001, 32'h0001_2345, eh, el);
    start(6'h18, 32'hFFFF_0001, 32'h0001_2345);
    repeat (4) @(posedge CLK);
    #1;
    op_valid = 1'b1; funct = 6'h12;
    #1;
    n = 0;
    while (stall === 1'b1 && n < 50) begin
      n++;
      @(posedge CLK); #1;
    end
    chk("mflo_stall_cycles", n, 29);
    chk("mflo_data", mf_data, el);
    chk("mflo_lo", lo, el);
    @(posedge CLK); #1;
    op_valid = 1'b0; funct = 6'h00;
    m_hi = eh; m_lo = el;

    // MTHI from reset state, then MFHI and a killed multiply
    RST = 1'b0; #1;
    chk("async_rst_hi", hi, 0);
    RST = 1'b1;
    @(posedge CLK); #1;
    op_valid = 1'b1; funct = 6'h11; Rdata1 = 32'h1234;
    #1;
    chk("mthi_no_stall", stall, 0);
    @(posedge CLK); #1;
    op_valid = 1'b0;
    chk("mthi_hi", hi, 32'h1234);
    chk("mthi_lo", lo, 0);
    m_hi = 32'h1234; m_lo = '0;
    op_valid = 1'b1; funct = 6'h10;
    #1;
    chk("mfhi_data", mf_data, 32'h1234);
    op_valid = 1'b0; funct = 6'h00;

    start(6'h18, 32'd5, 32'd9);
    repeat (4) @(posedge CLK);
    #1;
    op_valid = 1'b1; funct = 6'h20;
    #1;
    chk("unrecognised_no_stall", stall, 0);
    op_valid = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    kill = 1'b1; op_valid = 1'b1; funct = 6'h13; Rdata1 = 32'hDEAD;
    #1;
    chk("kill_masks_stall", stall, 0);
    chk("busy_before_kill", busy, 1);
    @(posedge CLK); #1;
    kill = 1'b0; op_valid = 1'b0; funct = 6'h00;
    chk("kill_busy_drop", busy, 0);
    chk("kill_mtlo_ignored", lo, m_lo);
    n = 0;
    repeat (30) begin
      @(posedge CLK); #1;
      if (done === 1'b1) n++;
    end
    chk("kill_no_done", n, 0);
    chk("kill_hi_kept", hi, 32'h1234);

    // Kill arriving in the FIX cycle
    start(6'h19, 32'd3, 32'd3);
    wait_done(cyc);
    chk("fixkill_cycle", cyc, 33);
    kill = 1'b1;
    #1;
    chk("fixkill_done_masked", done, 0);
    @(posedge CLK); #1;
    kill = 1'b0;
    chk("fixkill_busy", busy, 0);
    chk("fixkill_hi", hi, m_hi);
    chk("fixkill_lo", lo, m_lo);

    // Request arriving in the FIX cycle waits one cycle
    model(6'h1B, 32'd1000, 32'd3, eh, el);
    start(6'h1B, 32'd1000, 32'd3);
    wait_done(cyc);
    op_valid = 1'b1; funct = 6'h13; Rdata1 = 32'hCAFE;
    #1;
    chk("fix_req_stall", stall, 1);
    @(posedge CLK); #1;
    chk("fix_req_hi", hi, eh);
    chk("fix_req_lo", lo, el);
    chk("fix_req_released", stall, 0);
    @(posedge CLK); #1;
    op_valid = 1'b0; funct = 6'h00;
    chk("fix_req_mtlo", lo, 32'hCAFE);
    m_hi = eh; m_lo = 32'hCAFE;
    kill = 1'b1;
    @(posedge CLK); #1;
    kill = 1'b0;
    chk("idle_kill_busy", busy, 0);
    chk("idle_kill_lo", lo, 32'hCAFE);

`ifdef MULDIV_DIV0_TRAP_EN
    start(6'h1B, 32'd5, 32'd0);
    chk("trap_div0_pulse", div0_err, 1);
    chk("trap_busy", busy, 0);
    @(posedge CLK); #1;
    chk("trap_div0_clear", div0_err, 0);
    chk("trap_done", done, 0);
    chk("trap_hi", hi, m_hi);
    chk("trap_lo", lo, m_lo);
    start(6'h1A, 32'hFFFF_FFF0, 32'd0);
    chk("trap_sdiv0_pulse", div0_err, 1);
    chk("trap_sdiv0_busy", busy, 0);
    @(posedge CLK); #1;
    chk("trap_sdiv0_lo", lo, m_lo);
`else
    run_op(6'h1B, 32'd5, 32'd0);
    chk("div0_lo_ones", lo, 32'hFFFF_FFFF);
    chk("div0_hi_rs", hi, 32'd5);
    chk("div0_err_tied", div0_err, 0);
    run_op(6'h1A, 32'hFFFF_FFF0, 32'd0);
    chk("sdiv0_hi_raw", hi, 32'hFFFF_FFF0);
`endif

    for (int i = 0; i < 16; i++) begin
      f = 6'h18 + 6'($urandom_range(0, 3));
      a = $urandom >> $urandom_range(0, 31);
      b = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) a = -a;
      if ($urandom_range(0, 1) == 1) b = -b;
      if (b == 0) b = 32'd1;
      run_op(f, a, b);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
